// File: rtl/sscg_pkg.sv
// Shared constants for the sequence serial code generator: step modes, default
// pattern/tap/detector values and the hit-count saturation helper.
package sscg_pkg;

    localparam logic [1:0]  MODE_ROL    = 2'b00;
    localparam logic [1:0]  MODE_ROR    = 2'b01;
    localparam logic [1:0]  MODE_LFSR   = 2'b10;
    localparam logic [1:0]  MODE_HOLD   = 2'b11;

    localparam logic [15:0] DEF_PRESET  = 16'h0D95;
    localparam logic [15:0] DEF_TAPS    = 16'hB400;
    localparam logic [4:0]  DEF_DET_PAT = 5'b10110;
    localparam logic [7:0]  HIT_MAX     = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        r = (v == HIT_MAX) ? v : v + 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/seq_pat_det.sv
// Serial pattern detector: shifts the emitted bit into a history window and
// pulses det_hit (with a saturating count) when a full window equals DET_PAT.
module seq_pat_det
    import sscg_pkg::*;
#(
    parameter int               DET_W   = 5,
    parameter logic [DET_W-1:0] DET_PAT = DEF_DET_PAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en,
    input  logic       bit_in,
    input  logic       clr,
    output logic       det_hit,
    output logic [7:0] hit_cnt
);

    localparam int               FILL_W    = $clog2(DET_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DET_W);

    logic [DET_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_det_hit;
    logic [7:0]        r_hit_cnt;

    logic [DET_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_match;

    // The match is judged on the window including the bit being shifted in now.
    assign w_hist_nxt = {r_hist[DET_W-2:0], bit_in};
    assign w_fill_nxt = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    assign w_match    = (w_hist_nxt == DET_PAT) && (w_fill_nxt == FILL_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_det_hit <= 1'b0;
            r_hit_cnt <= '0;
        end else if (clr) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_det_hit <= 1'b0;
            r_hit_cnt <= '0;
        end else begin
            r_det_hit <= shift_en && w_match;
            if (shift_en) begin
                r_hist <= w_hist_nxt;
                r_fill <= w_fill_nxt;
                if (w_match)
                    r_hit_cnt <= sat_inc(r_hit_cnt);
            end
        end
    end

    assign det_hit = r_det_hit;
    assign hit_cnt = r_hit_cnt;

endmodule

// File: rtl/sscg_param.sv
// Sequence serial code generator: prescaled pattern register that rotates or
// runs as a Fibonacci LFSR, with serial output, LED view and pattern detector.
module sscg_param
    import sscg_pkg::*;
#(
    parameter int               W       = 16,
    parameter logic [W-1:0]     PRESET  = DEF_PRESET,
    parameter logic [W-1:0]     TAPS    = DEF_TAPS,
    parameter int               DIV     = 1,
    parameter int               DET_W   = 5,
    parameter logic [DET_W-1:0] DET_PAT = DEF_DET_PAT,
    parameter int               LED_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             load_sel,
    input  logic [W-1:0]     pat_in,
    input  logic [1:0]       mode,
    output logic [W-1:0]     seq,
    output logic             ser_out,
    output logic             step,
    output logic             det_hit,
    output logic [7:0]       hit_cnt,
    output logic [LED_W-1:0] led
);

    localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_seq;
    logic             r_step;

    logic             w_tick;
    logic             w_shift;
    logic             w_ser;

    function automatic logic [W-1:0] next_seq(input logic [W-1:0] s, input logic [1:0] m);
        logic [W-1:0] r;
        r = s;
        case (m)
            MODE_ROL:  r = {s[W-2:0], s[W-1]};
            MODE_ROR:  r = {s[0], s[W-1:1]};
            // An all-zero register would lock the LFSR forever; kick it to 1.
            MODE_LFSR: r = (s == '0) ? W'(1) : {s[W-2:0], ^(s & TAPS)};
            default:   r = s;
        endcase
        return r;
    endfunction

    assign w_tick  = en && (r_cnt == CNT_LAST);
    assign w_shift = w_tick && !load && (mode != MODE_HOLD);
    assign w_ser   = (mode == MODE_ROR) ? r_seq[0] : r_seq[W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_seq  <= '0;
            r_step <= 1'b0;
        end else if (load) begin
            r_cnt  <= '0;
            r_seq  <= load_sel ? pat_in : PRESET;
            r_step <= 1'b0;
        end else begin
            if (en)
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            r_step <= w_shift;
            if (w_shift)
                r_seq <= next_seq(r_seq, mode);
        end
    end

    // The detector sees the pre-shift emitted bit on every real step.
    seq_pat_det #(
        .DET_W   (DET_W),
        .DET_PAT (DET_PAT)
    ) u_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (w_shift),
        .bit_in   (w_ser),
        .clr      (load),
        .det_hit  (det_hit),
        .hit_cnt  (hit_cnt)
    );

    assign seq     = r_seq;
    assign ser_out = w_ser;
    assign step    = r_step;
    assign led     = r_seq[LED_W-1:0];

endmodule

// File: tb/tb_sscg_param.sv
// Bench for sscg_param: DIV=1 and DIV=4 instances share stimulus; a queue-based
// scoreboard checks every cycle against an arithmetic reference model.
module tb_sscg_param;
    import sscg_pkg::*;

    typedef struct packed {
        logic [15:0] seq;
        logic        ser;
        logic        step;
        logic        hit;
        logic [7:0]  cnt;
        logic [4:0]  led;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en = 1'b0, load = 1'b0, load_sel = 1'b0;
    logic [15:0] pat_in = '0;
    logic [1:0]  mode = 2'b00;

    logic [15:0] seq_a, seq_b;
    logic        ser_a, ser_b, step_a, step_b, hit_a, hit_b;
    logic [7:0]  cnt_a, cnt_b;
    logic [4:0]  led_a, led_b;

    int vectors = 0;
    int fails   = 0;

    logic [15:0] m_seq [2];
    int          m_cnt [2];
    logic        m_step[2];
    logic        m_hit [2];
    int          m_hits[2];
    bit          win_a[$];
    bit          win_b[$];
    obs_t        exp_a[$];
    obs_t        exp_b[$];
    logic [4:0]  pat = 5'b10110;

    always #5 clk = ~clk;

    sscg_param #(.DIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_sel(load_sel),
        .pat_in(pat_in), .mode(mode), .seq(seq_a), .ser_out(ser_a), .step(step_a),
        .det_hit(hit_a), .hit_cnt(cnt_a), .led(led_a)
    );

    sscg_param #(.DIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_sel(load_sel),
        .pat_in(pat_in), .mode(mode), .seq(seq_b), .ser_out(ser_b), .step(step_b),
        .det_hit(hit_b), .hit_cnt(cnt_b), .led(led_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Last DET_W emitted bits, oldest first, against the pattern (MSB = oldest).
    function automatic bit tail_match(input bit q[$]);
        if (q.size() != 5) return 1'b0;
        for (int i = 0; i < 5; i++)
            if (q[i] != pat[4-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_one(input int k, input int div);
        int  v;
        bit  b, tick, hitnow;
        if (!rst_n || load) begin
            m_seq[k]  = !rst_n ? 16'h0000 : (load_sel ? pat_in : 16'h0D95);
            m_cnt[k]  = 0;
            m_step[k] = 1'b0;
            m_hit[k]  = 1'b0;
            m_hits[k] = 0;
            if (k == 0) win_a.delete(); else win_b.delete();
            return;
        end
        tick = en && (m_cnt[k] == div - 1);
        if (en) m_cnt[k] = (m_cnt[k] + 1) % div;
        m_step[k] = 1'b0;
        m_hit[k]  = 1'b0;
        if (tick && mode != 2'b11) begin
            v = int'(m_seq[k]);
            b = (mode == 2'b01) ? m_seq[k][0] : m_seq[k][15];
            case (mode)
                2'b00:   v = (v * 2) % 65536 + v / 32768;
                2'b01:   v = v / 2 + (v % 2) * 32768;
                default: v = (v == 0) ? 1 : (v * 2) % 65536 + ($countones(m_seq[k] & 16'hB400) % 2);
            endcase
            m_seq[k]  = 16'(v);
            m_step[k] = 1'b1;
            if (k == 0) begin
                win_a.push_back(b);
                if (win_a.size() > 5) void'(win_a.pop_front());
                hitnow = tail_match(win_a);
            end else begin
                win_b.push_back(b);
                if (win_b.size() > 5) void'(win_b.pop_front());
                hitnow = tail_match(win_b);
            end
            if (hitnow) begin
                m_hit[k] = 1'b1;
                if (m_hits[k] < 255) m_hits[k]++;
            end
        end
    endtask

    function automatic obs_t obs(input int k);
        obs_t o;
        o.seq  = m_seq[k];
        o.ser  = (mode == 2'b01) ? m_seq[k][0] : m_seq[k][15];
        o.step = m_step[k];
        o.hit  = m_hit[k];
        o.cnt  = 8'(m_hits[k]);
        o.led  = m_seq[k][4:0];
        return o;
    endfunction

    task automatic cyc();
        model_one(0, 1);
        model_one(1, 4);
        exp_a.push_back(obs(0));
        exp_b.push_back(obs(1));
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            chk("div1_obs", {seq_a, ser_a, step_a, hit_a, cnt_a, led_a}, e);
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            chk("div4_obs", {seq_b, ser_b, step_b, hit_b, cnt_b, led_b}, e);
        end
    end

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_a", {seq_a, step_a, hit_a, cnt_a, led_a}, '0);
        chk("reset_b", {seq_b, step_b, hit_b, cnt_b, led_b}, '0);
        @(negedge clk); #1;
        run(2);
        rst_n = 1'b1;

        // Rotate-left from PRESET, full period
        en = 1'b1; mode = 2'b00; load = 1'b1; load_sel = 1'b0;
        cyc();
        load = 1'b0;
        chk("rol_load", seq_a, 16'h0D95);
        cyc(); chk("rol_1", seq_a, 16'h1B2A);
        cyc(); chk("rol_2", seq_a, 16'h3654);
        run(14); chk("rol_16", seq_a, 16'h0D95);

        // Detector: hit on step 10, then every 16 steps
        load = 1'b1; cyc(); load = 1'b0;
        run(9);  chk("det_9", {hit_a, cnt_a}, {1'b0, 8'd0});
        cyc();   chk("det_10", {hit_a, cnt_a}, {1'b1, 8'd1});
        run(16); chk("det_26", {hit_a, cnt_a}, {1'b1, 8'd2});
        load = 1'b1; cyc(); load = 1'b0;
        chk("det_clr", cnt_a, 8'd0);

        // Rotate-right with LED view
        load = 1'b1; load_sel = 1'b1; pat_in = 16'h0D95; mode = 2'b01; cyc(); load = 1'b0;
        chk("ror_led0", led_a, 5'h15);
        cyc(); chk("ror_1", {seq_a, led_a}, {16'h86CA, 5'h0A});
        cyc(); chk("ror_2", {seq_a, led_a}, {16'h4365, 5'h05});

        // LFSR: maximal period, then lock-up escape
        mode = 2'b10; pat_in = 16'h0001; load = 1'b1; cyc(); load = 1'b0;
        cyc(); chk("lfsr_1", seq_a, 16'h0002);
        run(65535); chk("lfsr_period", seq_a, 16'h0002);
        pat_in = 16'h0000; load = 1'b1; cyc(); load = 1'b0;
        chk("lfsr_zero", seq_a, 16'h0000);
        cyc(); chk("lfsr_escape", seq_a, 16'h0001);

        // DIV=4 prescaler, en gaps and hold mode
        mode = 2'b00; load_sel = 1'b0; load = 1'b1; cyc(); load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); chk("div4_step", step_b, (i == 3));
        end
        cyc(); chk("div4_gap0", step_b, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("div4_en_low", step_b, 1'b0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("div4_resume", step_b, (i == 2));
        end
        mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            cyc(); chk("hold", {step_a, step_b, hit_a, hit_b, seq_a}, {4'b0000, m_seq[0]});
        end

        // Load coincident with tick wins over the shift
        mode = 2'b00; load = 1'b1; load_sel = 1'b1; pat_in = 16'h1234; cyc(); load = 1'b0;
        chk("load_tick", {seq_a, step_a}, {16'h1234, 1'b0});

        // Asynchronous reset mid-run, no implied load
        load_sel = 1'b0; load = 1'b1; cyc(); load = 1'b0;
        run(20);
        rst_n = 1'b0;
        #1;
        chk("areset_a", {seq_a, ser_a, step_a, hit_a, cnt_a, led_a}, '0);
        chk("areset_b", {seq_b, ser_b, step_b, hit_b, cnt_b, led_b}, '0);
        @(negedge clk); #1;
        run(2);
        rst_n = 1'b1;
        cyc(); chk("rol_zero", seq_a, 16'h0000);
        mode = 2'b10;
        cyc(); chk("rst_escape", seq_a, 16'h0001);

        // Hit-count saturation
        mode = 2'b00; load = 1'b1; cyc(); load = 1'b0;
        run(4800); chk("hit_sat", cnt_a, 8'd255);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 31) == 0);
            load_sel = 1'($urandom_range(0, 1));
            pat_in   = 16'($urandom);
            mode     = 2'($urandom_range(0, 3));
            cyc();
        end
        load = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
